// File: rtl/cam_stream_gen_if.sv
// Camera-side pixel bus (vsync/href/byte) between cam_stream_gen and cam_read.
interface cam_stream_gen_if;
    logic       CAM_vsync;
    logic       CAM_href;
    logic [7:0] CAM_px_data;

    modport master (output CAM_vsync, output CAM_href, output CAM_px_data);
    modport slave  (input  CAM_vsync, input  CAM_href, input  CAM_px_data);
endinterface

// File: rtl/cam_stream_gen.sv
// OV7670-style RGB444 frame generator: vsync/href framing plus built-in test patterns.
// Stage 0 holds the frame FSM and pattern state; stage 1 registers every output.
module cam_stream_gen #(
    parameter int H_ACTIVE    = 160,
    parameter int V_ACTIVE    = 120,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic [1:0]       pattern,
    input  logic [11:0]      solid_color,
    cam_stream_gen_if.master cam,
    output logic             frame_done,
    output logic             busy,
    output logic [7:0]       frame_cnt
);
    localparam int LINE_BYTES = 2 * H_ACTIVE;
    localparam int L          = LINE_BYTES + H_BLANK;
    localparam int LP_W       = $clog2(L);
    localparam int LN_W       = $clog2(V_ACTIVE + VSYNC_LINES + V_BACK + V_FRONT + 1);
    localparam int BAR_PIX    = H_ACTIVE / 8;
    localparam int SUB_W      = $clog2(BAR_PIX + 1);

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT} state_t;

    state_t            state_p0, state_nx;
    logic [LP_W-1:0]   lp_p0, lp_nx;
    logic [LN_W-1:0]   line_p0, line_nx;
    logic              lp_last, enter_vsync, frame_end, pix_step;
    logic              done_p0;
    logic [1:0]        pat_l;
    logic [11:0]       solid_l;
    logic [3:0]        grad_b_l, cnt_start;
    logic [2:0]        bar_idx;
    logic [SUB_W-1:0]  bar_sub;
    logic [11:0]       idx_cnt, pix;
    logic [3:0]        x_lo, y_lo;
    logic              vsync_p1, href_p1, done_p1, busy_p1;
    logic [7:0]        data_p1, frame_cnt_p1;

    function automatic logic [11:0] bar_color(input logic [2:0] bar);
        case (bar)
            3'd0:    return 12'hFFF;
            3'd1:    return 12'hFF0;
            3'd2:    return 12'h0FF;
            3'd3:    return 12'h0F0;
            3'd4:    return 12'hF0F;
            3'd5:    return 12'hF00;
            3'd6:    return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [7:0] pix_byte(input logic [11:0] p, input logic second);
        return second ? p[7:0] : {4'h0, p[11:8]};
    endfunction

    assign lp_last  = (lp_p0 == LP_W'(L - 1));
    assign pix_step = (state_p0 == ACTIVE) && lp_p0[0];
    // A new frame sees the count as it will read once any pending increment lands.
    assign cnt_start = frame_cnt_p1[3:0] + 4'(done_p0) + 4'(frame_end);

    always_comb begin
        state_nx    = state_p0;
        lp_nx       = lp_last ? '0 : lp_p0 + LP_W'(1);
        line_nx     = line_p0;
        enter_vsync = 1'b0;
        frame_end   = 1'b0;
        unique case (state_p0)
            IDLE: begin
                lp_nx   = '0;
                line_nx = '0;
                if (start || continuous) begin
                    state_nx    = VSYNC;
                    enter_vsync = 1'b1;
                end
            end
            VSYNC: if (lp_last) begin
                if (line_p0 == LN_W'(VSYNC_LINES - 1)) begin
                    state_nx = VBACK;
                    line_nx  = '0;
                end else line_nx = line_p0 + LN_W'(1);
            end
            VBACK: if (lp_last) begin
                if (line_p0 == LN_W'(V_BACK - 1)) begin
                    state_nx = ACTIVE;
                    line_nx  = '0;
                end else line_nx = line_p0 + LN_W'(1);
            end
            ACTIVE: if (lp_p0 == LP_W'(LINE_BYTES - 1)) state_nx = HBLANK;
            HBLANK: if (lp_last) begin
                if (line_p0 == LN_W'(V_ACTIVE - 1)) begin
                    state_nx = VFRONT;
                    line_nx  = '0;
                end else begin
                    state_nx = ACTIVE;
                    line_nx  = line_p0 + LN_W'(1);
                end
            end
            VFRONT: if (lp_last) begin
                if (line_p0 == LN_W'(V_FRONT - 1)) begin
                    frame_end = 1'b1;
                    line_nx   = '0;
                    if (continuous) begin
                        state_nx    = VSYNC;
                        enter_vsync = 1'b1;
                    end else state_nx = IDLE;
                end else line_nx = line_p0 + LN_W'(1);
            end
            default: state_nx = IDLE;
        endcase
    end

    // stage 0: frame FSM, line timing and pattern state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_p0 <= IDLE;
            lp_p0    <= '0;
            line_p0  <= '0;
            done_p0  <= 1'b0;
            pat_l    <= '0;
            solid_l  <= '0;
            grad_b_l <= '0;
            bar_idx  <= '0;
            bar_sub  <= '0;
            idx_cnt  <= '0;
        end else begin
            state_p0 <= state_nx;
            lp_p0    <= lp_nx;
            line_p0  <= line_nx;
            done_p0  <= frame_end;
            if (enter_vsync) begin
                pat_l    <= pattern;
                solid_l  <= solid_color;
                grad_b_l <= cnt_start;
            end
            if (state_p0 != ACTIVE) begin
                bar_idx <= '0;
                bar_sub <= '0;
            end else if (pix_step) begin
                if (bar_sub == SUB_W'(BAR_PIX - 1)) begin
                    bar_sub <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else bar_sub <= bar_sub + SUB_W'(1);
            end
            if (enter_vsync)   idx_cnt <= '0;
            else if (pix_step) idx_cnt <= idx_cnt + 12'd1;
        end
    end

    assign x_lo = 4'(lp_p0 >> 1);
    assign y_lo = 4'(line_p0);

    always_comb begin
        case (pat_l)
            2'd0:    pix = solid_l;
            2'd1:    pix = bar_color(bar_idx);
            2'd2:    pix = {x_lo, y_lo, grad_b_l};
            default: pix = idx_cnt;
        endcase
    end

    // stage 1: registered camera bus and status
    always_ff @(posedge clk) begin
        if (!rst) begin
            vsync_p1     <= 1'b0;
            href_p1      <= 1'b0;
            data_p1      <= 8'h00;
            done_p1      <= 1'b0;
            busy_p1      <= 1'b0;
            frame_cnt_p1 <= 8'h00;
        end else begin
            vsync_p1     <= (state_p0 == VSYNC);
            href_p1      <= (state_p0 == ACTIVE);
            data_p1      <= (state_p0 == ACTIVE) ? pix_byte(pix, lp_p0[0]) : 8'h00;
            done_p1      <= done_p0;
            busy_p1      <= (state_p0 != IDLE);
            frame_cnt_p1 <= frame_cnt_p1 + 8'(done_p0);
        end
    end

    assign cam.CAM_vsync   = vsync_p1;
    assign cam.CAM_href    = href_p1;
    assign cam.CAM_px_data = data_p1;
    assign frame_done      = done_p1;
    assign busy            = busy_p1;
    assign frame_cnt       = frame_cnt_p1;
endmodule

// File: doc/cam_stream_gen.md
Name: cam_stream_gen

Overview:
- Synthesizable OV7670-style pixel-stream transmitter: the other end of the cam_read capture interface.
- Generates CAM_vsync, CAM_href and CAM_px_data framing in RGB444 two-byte format from built-in test patterns.
- Replaces the hand-written camera stimulus in test_cam simulation.
- Can also drive cam_read on the board with the real camera disconnected.

Parameters:
H_ACTIVE, 160, pixels per line; multiple of 8.
V_ACTIVE, 120, active lines per frame.
H_BLANK, 144, href-low cycles after each line's active bytes.
VSYNC_LINES, 3, line periods with vsync high.
V_BACK, 17, blank line periods after vsync.
V_FRONT, 10, blank line periods after the last active line.

Ports:
clk  in  1  pixel clock; it also feeds cam_read's CAM_pclk, and all outputs change on its rising edge.
rst  in  1  synchronous, active-low reset.
start  in  1  request one frame; sampled in IDLE only.
continuous  in  1  1 = restart immediately after each frame.
pattern  in  2  0 solid, 1 colour bars, 2 gradient, 3 index.
solid_color  in  12  RGB444 colour used by pattern 0.
CAM_vsync  out  1  frame sync, active high.
CAM_href  out  1  line valid, active high.
CAM_px_data  out  8  pixel byte.
frame_done  out  1  one-cycle pulse at end of frame.
busy  out  1  high in every state except IDLE.
frame_cnt  out  8  completed frames; wraps at 255->0.

Behaviour:
- Line period L = 2*H_ACTIVE + H_BLANK cycles.
- Reset (rst=0 at an edge, including mid-frame):
  - State goes to IDLE.
  - All outputs become 0 after that edge; frame_cnt=0.
  - Pattern latches are cleared.
- States:
  - IDLE: all outputs low. start=1 or continuous=1 -> VSYNC.
  - VSYNC: CAM_vsync=1 for VSYNC_LINES*L cycles -> VBACK.
  - VBACK: all low for V_BACK*L cycles -> ACTIVE.
  - ACTIVE: CAM_href=1 for 2*H_ACTIVE cycles -> HBLANK.
  - HBLANK: href=0 for H_BLANK cycles. Goes to ACTIVE if lines remain, else VFRONT.
  - VFRONT: all low for V_FRONT*L cycles, then FRAME_END transition.
  - FRAME_END transition: frame_done=1 for one cycle; frame_cnt increments in the same cycle.
    - If continuous=1, VSYNC starts in that same cycle (vsync=1 alongside frame_done).
    - Else go to IDLE.
- start is ignored while busy. frame_cnt is never reset by start.
- pattern and solid_color are latched on entry to VSYNC. Changes mid-frame take effect next frame.
- Pixel x (0..H_ACTIVE-1), line y (0..V_ACTIVE-1); pixel p = {R,G,B} is emitted as two bytes:
  - first byte {4'h0, R}
  - second byte {G, B}
  - first byte is on the first href-high cycle of each pair.
- CAM_px_data = 8'h00 whenever href=0.
- Patterns:
  - 0: p = latched solid_color.
  - 1: bar = x / (H_ACTIVE/8). bar 0..7 = FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000. Implemented with a bar counter and a sub-counter, no divider.
  - 2: R = x[3:0], G = y[3:0], B = frame_cnt[3:0] (value at frame start).
  - 3: p = (y*H_ACTIVE + x) mod 4096. Implemented as a running 12-bit index counter that wraps and is cleared at VSYNC entry, giving p = cam_read write address[11:0].
- Counters: byte counter, line-period counter and line counter are sized by $clog2 of the parameter products. No truncation for default values.

Test Plan:
- Setup for scenarios 1–4: H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1 (L=20). Cycle 0 = edge where start is sampled.
1. start pulse in IDLE, pattern=0, solid_color=12'hA5C:
   - vsync high cycles 1–20.
   - href high cycles 41–56, 61–76, 81–96, 101–116.
   - bytes alternate 0A, 5C.
   - frame_done high only in cycle 141, then IDLE, busy=0, frame_cnt=1.
2. pattern=1, H_ACTIVE=8, one frame: each line's bytes are 0F,FF, 0F,F0, 00,FF, 00,F0, 0F,0F, 0F,00, 00,0F, 00,00.
3. pattern=3: line 2 second pixel (x=1) bytes are 00,11 (index 17). Line 3 last pixel bytes are 00,1F (index 31).
4. continuous=1 for three frames:
   - frame_done and vsync rise together at cycles 141 and 281.
   - gradient B byte nibble follows frame_cnt 0,1,2.
   - pattern changed mid-frame applies only from the next vsync.
5. Default parameters, test_cam bench with this block driving cam_read:
   - 160x120 frame.
   - pattern=3: RAM word at address a equals a[11:0] for all 19200 addresses.
   - pattern=1: RAM address 20 = FF0.
6. rst=0 asserted in cycle 50 (mid-href): all outputs 0 from cycle 51. start then produces a clean full frame from vsync.
